mem_responder: RTL

Synthesizable responder for the `mem_intf` memory bus: it accepts single-byte write and read requests from the initiator, holds `busy` for a fixed, parameterized latency, and then commits the write or returns read data with a one-cycle `rd_rdy` pulse. It is the DUT-side endpoint the testbench driver and monitor talk to. It also serves as a latency-accurate stand-in for the HyperRAM controller in bus-level regressions.

---
 rtl/mem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port byte memory responder for the mem_intf bus: accepts one write or read at a time,
// holds busy for a fixed latency, then commits the write or returns data with an rd_rdy pulse.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned WR_LAT     = 2,
  parameter int unsigned RD_LAT     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        rd_rdy,
  output logic        err
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned MaxLat = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic                  done;
  logic                  mem_we;
  logic [7:0]            mem [Depth];

  // Upper address bits alias onto the populated range.
  logic unused_addr;
  assign unused_addr = ^addr[31:DEPTH_LOG2];

  always_comb begin
    done   = 1'b0;
    mem_we = 1'b0;
    if (state_q != StIdle && cnt_q == CntW'(1)) begin
      done   = 1'b1;
      mem_we = (state_q == StWrite);
    end
  end

  // Storage is deliberately left out of reset; an async reset forces state_q to idle, which
  // drops mem_we and so discards any uncommitted write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      rd_rdy  <= 1'b0;
      err     <= 1'b0;
    end else begin
      rd_rdy <= 1'b0;
      err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_en && rd_en) begin
            err <= 1'b1;
          end else if (wr_en) begin
            state_q <= StWrite;
            cnt_q   <= CntW'(WR_LAT);
            addr_q  <= addr[DEPTH_LOG2-1:0];
            wdata_q <= wdata;
            busy    <= 1'b1;
          end else if (rd_en) begin
            state_q <= StRead;
            cnt_q   <= CntW'(RD_LAT);
            addr_q  <= addr[DEPTH_LOG2-1:0];
            busy    <= 1'b1;
          end
        end
        StWrite, StRead: begin
          // Any request while busy is rejected, including on the completion edge.
          if (wr_en || rd_en) begin
            err <= 1'b1;
          end
          if (done) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy    <= 1'b0;
            if (state_q == StRead) begin
              rdata  <= mem[addr_q];
              rd_rdy <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
